eth_pcs_blk_sync: RTL and testbench

- Parametrised RX 66b block-lock synchroniser plus high-BER monitor: successor to the fixed-threshold block sync (fixed SH_TH = 64, SH_INVAL_TH = 16).
- Sits between the RX gearbox and the RX descrambler/decoder.
- Inspects each 2-bit sync header, commands gearbox bit-slips until lock, and reports block_lock and hi_ber (IEEE 802.3 cl.49 lock and BER state machines).
- Thresholds, post-slip settle time and BER window are parameters; the BER monitor can be compiled out.

---
 rtl/eth_pcs_params.sv | 26 ++
 rtl/eth_pcs_ber_mon.sv | 73 +++++++
 rtl/eth_pcs_blk_sync.sv | 142 ++++++++++++++
 tb/tb_eth_pcs_blk_sync.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pcs_params.sv
// Shared constants, lock-state encoding and header classification for the
// 10GBASE-R receive block-lock path.
package eth_pcs_params;

    localparam int W_SYNC = 2;
    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

    localparam int SH_TH_DEF       = 64;
    localparam int SH_INVAL_TH_DEF = 16;
    localparam int SLIP_WAIT_DEF   = 4;
    localparam int BER_WIN_DEF     = 19531;
    localparam int BER_TH_DEF      = 16;
    localparam int W_BER_CNT       = 6;

    typedef enum logic [1:0] {
        ST_TEST,
        ST_SLIP_REQ,
        ST_SLIP_WAIT
    } lock_state_e;

    function automatic logic is_valid_sh(input logic [W_SYNC-1:0] sh);
        return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_pcs_ber_mon.sv
// High-BER monitor: counts invalid headers per fixed window of header strobes
// and keeps a saturating, host-clearable invalid-header count.
module eth_pcs_ber_mon
    import eth_pcs_params::*;
#(
    parameter int BER_WIN = BER_WIN_DEF,
    parameter int BER_TH  = BER_TH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lock,
    input  logic                 sh_evt,
    input  logic                 sh_bad,
    input  logic                 cnt_clr,
    output logic                 hi_ber,
    output logic [W_BER_CNT-1:0] ber_cnt
);

    localparam int W_WIN = $clog2(BER_WIN + 1);
    localparam int W_ERR = $clog2(BER_TH + 1);

    logic [W_WIN-1:0] win_cnt;
    logic [W_WIN-1:0] win_nxt;
    logic [W_ERR-1:0] err_cnt;
    logic [W_ERR-1:0] err_nxt;
    logic             win_end;
    logic             err_hit;
    logic             cnt_inc;

    always_comb begin
        win_nxt = win_cnt + W_WIN'(1);
        err_nxt = err_cnt;
        if (sh_bad && (err_cnt != W_ERR'(BER_TH)))
            err_nxt = err_cnt + W_ERR'(1);
        win_end = (win_nxt == W_WIN'(BER_WIN));
        err_hit = sh_bad && (err_nxt == W_ERR'(BER_TH));
        cnt_inc = lock && sh_evt && sh_bad;
    end

    // A window that ends on the threshold-reaching header still raises hi_ber.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            err_cnt <= '0;
            hi_ber  <= 1'b0;
        end else if (!lock) begin
            win_cnt <= '0;
            err_cnt <= '0;
        end else if (sh_evt) begin
            if (err_hit)
                hi_ber <= 1'b1;
            else if (win_end && (err_nxt < W_ERR'(BER_TH)))
                hi_ber <= 1'b0;
            if (win_end) begin
                win_cnt <= '0;
                err_cnt <= '0;
            end else begin
                win_cnt <= win_nxt;
                err_cnt <= err_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ber_cnt <= '0;
        else if (cnt_clr)
            ber_cnt <= cnt_inc ? W_BER_CNT'(1) : '0;
        else if (cnt_inc && (ber_cnt != '1))
            ber_cnt <= ber_cnt + W_BER_CNT'(1);
    end

endmodule

// File: rtl/eth_pcs_blk_sync.sv
// RX 66b block-lock synchroniser: tests sync headers, requests gearbox slips
// until a clean window is seen, and hosts the optional high-BER monitor.
module eth_pcs_blk_sync
    import eth_pcs_params::*;
#(
    parameter int SH_TH       = SH_TH_DEF,
    parameter int SH_INVAL_TH = SH_INVAL_TH_DEF,
    parameter int SLIP_WAIT   = SLIP_WAIT_DEF,
    parameter int BER_EN      = 1,
    parameter int BER_WIN     = BER_WIN_DEF,
    parameter int BER_TH      = BER_TH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sh_vld,
    input  logic [W_SYNC-1:0]    i_sync,
    input  logic                 i_slip_ack,
    output logic                 o_slip,
    output logic                 o_block_lock,
    output logic                 o_hi_ber,
    output logic [W_BER_CNT-1:0] o_ber_cnt,
    input  logic                 i_ber_cnt_clr
);

    localparam int W_SH   = $clog2(SH_TH) + 1;
    localparam int W_WAIT = $clog2(SLIP_WAIT + 1) + 1;

    lock_state_e       state;
    lock_state_e       state_nxt;
    logic [W_SH-1:0]   sh_cnt;
    logic [W_SH-1:0]   sh_cnt_nxt;
    logic [W_SH-1:0]   sh_inc;
    logic [W_SH-1:0]   inval_cnt;
    logic [W_SH-1:0]   inval_cnt_nxt;
    logic [W_SH-1:0]   inval_inc;
    logic [W_WAIT-1:0] wait_cnt;
    logic [W_WAIT-1:0] wait_cnt_nxt;
    logic [W_WAIT-1:0] wait_inc;
    logic              ack_seen;
    logic              ack_seen_nxt;
    logic              lock_nxt;
    logic              sh_bad;
    logic              sh_test;

    assign sh_bad  = !is_valid_sh(i_sync);
    assign sh_test = i_sh_vld && (state == ST_TEST);

    always_comb begin
        state_nxt     = state;
        sh_cnt_nxt    = sh_cnt;
        inval_cnt_nxt = inval_cnt;
        wait_cnt_nxt  = wait_cnt;
        ack_seen_nxt  = ack_seen;
        lock_nxt      = o_block_lock;
        sh_inc        = sh_cnt + W_SH'(1);
        inval_inc     = inval_cnt + W_SH'(sh_bad);
        wait_inc      = wait_cnt + W_WAIT'(1);
        case (state)
            ST_TEST: begin
                if (i_sh_vld) begin
                    if (sh_bad && (!o_block_lock || (inval_inc == W_SH'(SH_INVAL_TH)))) begin
                        state_nxt     = ST_SLIP_REQ;
                        lock_nxt      = 1'b0;
                        sh_cnt_nxt    = '0;
                        inval_cnt_nxt = '0;
                    end else if (sh_inc == W_SH'(SH_TH)) begin
                        if (inval_inc == '0)
                            lock_nxt = 1'b1;
                        sh_cnt_nxt    = '0;
                        inval_cnt_nxt = '0;
                    end else begin
                        sh_cnt_nxt    = sh_inc;
                        inval_cnt_nxt = inval_inc;
                    end
                end
            end
            ST_SLIP_REQ: begin
                sh_cnt_nxt    = '0;
                inval_cnt_nxt = '0;
                wait_cnt_nxt  = '0;
                ack_seen_nxt  = i_slip_ack;
                state_nxt     = ST_SLIP_WAIT;
            end
            ST_SLIP_WAIT: begin
                // Only strobes after the acknowledge count toward the settle time.
                if (!ack_seen) begin
                    ack_seen_nxt = i_slip_ack;
                end else if ((wait_cnt == W_WAIT'(SLIP_WAIT)) ||
                             (i_sh_vld && (wait_inc == W_WAIT'(SLIP_WAIT)))) begin
                    state_nxt    = ST_TEST;
                    ack_seen_nxt = 1'b0;
                    wait_cnt_nxt = '0;
                end else if (i_sh_vld) begin
                    wait_cnt_nxt = wait_inc;
                end
            end
            default: state_nxt = ST_TEST;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_TEST;
            sh_cnt       <= '0;
            inval_cnt    <= '0;
            wait_cnt     <= '0;
            ack_seen     <= 1'b0;
            o_slip       <= 1'b0;
            o_block_lock <= 1'b0;
        end else begin
            state        <= state_nxt;
            sh_cnt       <= sh_cnt_nxt;
            inval_cnt    <= inval_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
            ack_seen     <= ack_seen_nxt;
            o_slip       <= (state == ST_SLIP_REQ);
            o_block_lock <= lock_nxt;
        end
    end

    generate
        if (BER_EN != 0) begin : g_ber
            eth_pcs_ber_mon #(
                .BER_WIN (BER_WIN),
                .BER_TH  (BER_TH)
            ) u_ber_mon (
                .clk     (i_clk),
                .rst_n   (i_rst_n),
                .lock    (o_block_lock),
                .sh_evt  (sh_test),
                .sh_bad  (sh_test && sh_bad),
                .cnt_clr (i_ber_cnt_clr),
                .hi_ber  (o_hi_ber),
                .ber_cnt (o_ber_cnt)
            );
        end else begin : g_no_ber
            assign o_hi_ber  = 1'b0;
            assign o_ber_cnt = '0;
        end
    endgenerate

endmodule

// File: tb/tb_eth_pcs_blk_sync.sv
// Bench for eth_pcs_blk_sync: timed expectations go into a scoreboard queue
// keyed by cycle; window behaviour is swept from a table of header bursts.
module tb_eth_pcs_blk_sync;
    import eth_pcs_params::*;

    localparam int SH_TH       = 64;
    localparam int SH_INVAL_TH = 16;
    localparam int SLIP_WAIT   = 4;
    localparam int BER_WIN     = 2048;
    localparam int BER_TH      = 16;

    localparam int SIG_SLIP   = 0;
    localparam int SIG_LOCK   = 1;
    localparam int SIG_HIBER  = 2;
    localparam int SIG_BERCNT = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sh_vld = 1'b0;
    logic [W_SYNC-1:0]    sync = SYNC_DATA;
    logic                 slip_ack = 1'b0;
    logic                 ber_cnt_clr = 1'b0;
    logic                 slip;
    logic                 block_lock;
    logic                 hi_ber;
    logic [W_BER_CNT-1:0] ber_cnt;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    typedef struct {
        int n_inval;
        int n_clean;
        int exp_lock;
        int exp_slips;
        int exp_ber;
    } row_t;

    exp_t sbq[$];
    row_t tbl[5];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   slip_cnt = 0;
    int   base;
    logic [W_SYNC-1:0] s;

    always #5 clk = ~clk;

    eth_pcs_blk_sync #(
        .SH_TH       (SH_TH),
        .SH_INVAL_TH (SH_INVAL_TH),
        .SLIP_WAIT   (SLIP_WAIT),
        .BER_EN      (1),
        .BER_WIN     (BER_WIN),
        .BER_TH      (BER_TH)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sh_vld      (sh_vld),
        .i_sync        (sync),
        .i_slip_ack    (slip_ack),
        .o_slip        (slip),
        .o_block_lock  (block_lock),
        .o_hi_ber      (hi_ber),
        .o_ber_cnt     (ber_cnt),
        .i_ber_cnt_clr (ber_cnt_clr)
    );

    function automatic logic [W_SYNC-1:0] clean(input int i);
        return i[0] ? SYNC_CTRL : SYNC_DATA;
    endfunction

    function automatic int sig_val(input int sig);
        case (sig)
            SIG_SLIP:  return int'(slip);
            SIG_LOCK:  return int'(block_lock);
            SIG_HIBER: return int'(hi_ber);
            default:   return int'(ber_cnt);
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_SLIP:  return "slip";
            SIG_LOCK:  return "block_lock";
            SIG_HIBER: return "hi_ber";
            default:   return "ber_cnt";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic exp(input int dly, input int sig, input int val);
        exp_t e;
        e.cyc = cyc + dly;
        e.sig = sig;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic sb_check();
        if (slip === 1'b1)
            slip_cnt++;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                check($sformatf("sb %s cyc%0d", sig_name(sbq[i].sig), sbq[i].cyc),
                      (sbq[i].cyc == cyc) ? sig_val(sbq[i].sig) : -1, sbq[i].val);
                sbq.delete(i);
            end
        end
    endtask

    // Inputs change on the falling edge; outputs are checked on the next one.
    task automatic step(input logic v, input logic [W_SYNC-1:0] sh,
                        input logic ack, input logic clr);
        sh_vld      = v;
        sync        = sh;
        slip_ack    = ack;
        ber_cnt_clr = clr;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        sb_check();
    endtask

    task automatic lock_run();
        for (int i = 1; i <= SH_TH; i++) begin
            if (i == SH_TH - 1)
                exp(1, SIG_LOCK, 0);
            if (i == SH_TH)
                exp(1, SIG_LOCK, 1);
            step(1'b1, clean(i), 1'b0, 1'b0);
        end
    endtask

    initial begin
        tbl[0] = '{15, 49, 1, 0, 15};
        tbl[1] = '{15, 49, 1, 0, 30};
        tbl[2] = '{15, 49, 1, 0, 45};
        tbl[3] = '{15, 49, 1, 0, 60};
        tbl[4] = '{10,  0, 1, 0, 63};

        // Power-on reset
        step(1'b0, SYNC_DATA, 1'b0, 1'b0);
        step(1'b0, SYNC_DATA, 1'b0, 1'b0);
        check("reset slip", int'(slip), 0);
        check("reset block_lock", int'(block_lock), 0);
        check("reset hi_ber", int'(hi_ber), 0);
        check("reset ber_cnt", int'(ber_cnt), 0);
        rst_n = 1'b1;
        step(1'b0, SYNC_DATA, 1'b0, 1'b0);

        // Unlocked: bad header at strobe 5, ack after the pulse, settle strobes carry junk
        for (int i = 1; i <= 4; i++)
            step(1'b1, clean(i), 1'b0, 1'b0);
        base = slip_cnt;
        exp(1, SIG_SLIP, 0);
        exp(2, SIG_SLIP, 1);
        exp(3, SIG_SLIP, 0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < SLIP_WAIT; i++)
            step(1'b1, 2'b11, 1'b0, 1'b0);
        lock_run();
        check("slip pulses after unlocked error", slip_cnt - base, 1);

        // BER window 1: 16 errors spread over the first 960 strobes
        for (int i = 1; i <= BER_WIN; i++) begin
            s = (((i % 60) == 0) && (i <= 960)) ? 2'b00 : clean(i);
            if (i == 959)
                exp(1, SIG_HIBER, 0);
            if (i == 960 || i == BER_WIN)
                exp(1, SIG_HIBER, 1);
            step(1'b1, s, 1'b0, 1'b0);
        end
        // BER window 2: only 3 errors, hi_ber drops at the window end
        for (int i = 1; i <= BER_WIN; i++) begin
            s = (i == 100 || i == 200 || i == 300) ? 2'b11 : clean(i);
            if (i == BER_WIN - 1)
                exp(1, SIG_HIBER, 1);
            if (i == BER_WIN)
                exp(1, SIG_HIBER, 0);
            step(1'b1, s, 1'b0, 1'b0);
        end
        check("lock through BER windows", int'(block_lock), 1);
        check("ber_cnt after two windows", int'(ber_cnt), 19);
        step(1'b0, SYNC_DATA, 1'b0, 1'b1);
        check("ber_cnt cleared", int'(ber_cnt), 0);

        // Locked windows of 15 errors each, then saturation of ber_cnt
        base = slip_cnt;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < tbl[r].n_inval; i++)
                step(1'b1, i[0] ? 2'b11 : 2'b00, 1'b0, 1'b0);
            for (int i = 0; i < tbl[r].n_clean; i++)
                step(1'b1, clean(i), 1'b0, 1'b0);
            check($sformatf("row%0d lock", r), int'(block_lock), tbl[r].exp_lock);
            check($sformatf("row%0d slips", r), slip_cnt - base, tbl[r].exp_slips);
            check($sformatf("row%0d ber_cnt", r), int'(ber_cnt), tbl[r].exp_ber);
        end

        // Clear coincident with an error, then the 16th error of the window
        step(1'b1, 2'b11, 1'b0, 1'b1);
        check("clear with increment", int'(ber_cnt), 1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'b00, 1'b0, 1'b0);
        check("lock before 16th error", int'(block_lock), 1);
        base = slip_cnt;
        exp(1, SIG_LOCK, 0);
        exp(2, SIG_SLIP, 1);
        exp(3, SIG_SLIP, 0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < SLIP_WAIT; i++)
            step(1'b1, 2'b11, 1'b0, 1'b0);
        check("hi_ber holds after lock loss", int'(hi_ber), 1);
        lock_run();
        check("slip pulses after 16 errors", slip_cnt - base, 1);

        // Asynchronous reset while locked with hi_ber set
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst block_lock", int'(block_lock), 0);
        check("async rst hi_ber", int'(hi_ber), 0);
        check("async rst ber_cnt", int'(ber_cnt), 0);
        step(1'b0, SYNC_DATA, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, SYNC_DATA, 1'b0, 1'b0);

        // Reset asserted while the slip pulse is on the wire
        step(1'b1, SYNC_DATA, 1'b0, 1'b0);
        exp(1, SIG_SLIP, 0);
        exp(2, SIG_SLIP, 1);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b1, SYNC_DATA, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst drops slip", int'(slip), 0);
        step(1'b0, SYNC_DATA, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, SYNC_DATA, 1'b0, 1'b0);
        check("post-reset block_lock", int'(block_lock), 0);

        // Clean re-lock after reset: no slip at all
        base = slip_cnt;
        lock_run();
        check("no slip on clean lock", slip_cnt - base, 0);
        check("hi_ber after relock", int'(hi_ber), 0);
        check("ber_cnt after relock", int'(ber_cnt), 0);

        step(1'b0, SYNC_DATA, 1'b0, 1'b0);
        check("scoreboard drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
